// File: rtl/duty_value_display_pkg.sv
// Shared types and tables for the duty-cycle value display.
// Seven-segment patterns are active-low {g,f,e,d,c,b,a}.
package duty_value_display_pkg;

  localparam int DEF_DATA_W = 17;
  localparam int DEF_DIGITS = 6;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } conv_state_t;

  // Codes 10-15 cannot come out of the converter, so they blank
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'h7F,      7'h7F,
    7'h7F,      7'h7F,      7'h7F,      7'h7F
  };

endpackage

// File: rtl/duty_value_display_bin2bcd_seq.sv
// Sequential double-dabble converter; runs only when the input
// differs from the last converted value.
module bin2bcd_seq
  import duty_value_display_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  localparam int BW  = 4 * DIGITS;
  localparam int CW  = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  conv_state_t       state;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] cap_q;
  logic [DATA_W-1:0] src_q;
  logic [BW-1:0]     bcd_q;
  logic [BW-1:0]     adj;
  logic [CW-1:0]     bit_cnt;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift_q <= '0;
      cap_q   <= '0;
      src_q   <= '0;
      bcd_q   <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (value != src_q) begin
            shift_q <= value;
            cap_q   <= value;
            bcd_q   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd_q   <= {adj[BW-2:0], shift_q[DATA_W-1]};
          shift_q <= {shift_q[DATA_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == LAST)
            state <= DONE;
        end
        DONE: begin
          bcd   <= bcd_q;
          src_q <= cap_q;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/duty_value_display.sv
// Decimal display of the duty-cycle value on a multiplexed 7-seg.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits.
module duty_value_display
  import duty_value_display_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int DIGITS        = DEF_DIGITS,
  parameter int REFRESH_CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] value,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              busy
);

  localparam int IW = $clog2(DIGITS);

  logic [4*DIGITS-1:0]      disp_bcd;
  logic [REFRESH_CNT_W-1:0] prescaler;
  logic [IW-1:0]            digit_idx;
  bcd_t                     nib [DIGITS];
  logic [6:0]               pat;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .bcd   (disp_bcd),
    .busy  (busy)
  );

  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      nib[i] = disp_bcd[4*i +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              zero_run;

  // A digit blanks when it and everything above it is zero
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (nib[i] == 4'd0);
      blank[i] = zero_run;
    end
  end

  always_comb begin
    pat = SEG_LUT[nib[digit_idx]];
    if (blank[digit_idx])
      pat = 7'h7F;
  end
`else
  always_comb begin
    pat = SEG_LUT[nib[digit_idx]];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      digit_idx <= '0;
      an        <= '1;
      seg       <= 7'h7F;
    end else begin
      prescaler <= prescaler + REFRESH_CNT_W'(1);
      if (&prescaler)
        digit_idx <= (digit_idx == IW'(DIGITS - 1)) ? '0
                   : digit_idx + IW'(1);
      an  <= ~(DIGITS'(1) << digit_idx);
      seg <= pat;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_duty_value_display.sv
// Directed bench for duty_value_display with a fast refresh.
// Expected values are hand-derived decimal digits and segment codes.
module tb_duty_value_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] value;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S7 = 7'b1111000;

  duty_value_display #(
    .DATA_W        (17),
    .DIGITS        (6),
    .REFRESH_CNT_W (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .an    (an),
    .seg   (seg),
    .dp    (dp),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic see_digit(input int d, input logic [6:0] exp,
                           input string tag);
    logic [5:0] want;
    bit hit;
    want = ~(6'b000001 << d);
    hit  = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (an === want) hit = 1;
    end
    check({tag, "_scan"}, 32'(hit), 1);
    check(tag, 32'(seg), 32'(exp));
  endtask

  task automatic wait_idle(input string tag);
    bit hit;
    hit = 0;
    step(1);
    for (int k = 0; k < 60 && !hit; k++) begin
      if (busy === 1'b0) hit = 1;
      else step(1);
    end
    check(tag, 32'(hit), 1);
  endtask

  task automatic wait_an(input logic [5:0] want, input bit eq,
                         input string tag);
    bit hit;
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if ((an === want) == eq) hit = 1;
    end
    check(tag, 32'(hit), 1);
  endtask

  initial begin
    int cnt;
    int errs;
    rst_n = 1'b0;
    value = '0;
    step(3);
    check("rst_an", 32'(an), 32'h3F);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step(1);
    check("first_an", 32'(an), 32'h3E);
    check("first_seg", 32'(seg), 32'(S0));
    check("dp_off", 32'(dp), 1);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (busy !== 1'b0) cnt++;
      step(1);
    end
    check("zero_no_conv", cnt, 0);

    // 12345: busy after edges N..N+17, result after N+18
    value = 17'd12345;
    cnt = 0;
    for (int k = 0; k < 18; k++) begin
      step(1);
      if (busy === 1'b1) cnt++;
    end
    check("lat_busy", cnt, 18);
    step(1);
    check("lat_idle", 32'(busy), 0);
    check("lat_bcd", 32'(dut.disp_bcd), 32'h012345);
    see_digit(2, S3, "d2_12345");
    see_digit(0, 7'b0010010, "d0_12345");

    // Maximum value and anode scan order
    value = 17'd131071;
    wait_idle("max_idle");
    check("max_bcd", 32'(dut.disp_bcd), 32'h131071);
    see_digit(0, S1, "max_d0");
    see_digit(1, S7, "max_d1");
    see_digit(2, S0, "max_d2");
    see_digit(4, S3, "max_d4");
    wait_an(6'b011111, 1, "scan_find5");
    wait_an(6'b011111, 0, "scan_leave5");
    errs = 0;
    for (int k = 0; k < 24; k++) begin
      if (an !== ~(6'b000001 << (k / 4))) errs++;
      step(1);
    end
    check("an_seq", errs, 0);
    check("an_wrap", 32'(an), 32'h3E);

    // Change during conversion
    value = 17'd500;
    step(5);
    value = 17'd777;
    step(13);
    check("chg_busy17", 32'(busy), 1);
    check("chg_old", 32'(dut.disp_bcd), 32'h131071);
    step(1);
    check("chg_first", 32'(dut.disp_bcd), 32'h000500);
    check("chg_idle18", 32'(busy), 0);
    step(1);
    check("chg_restart", 32'(busy), 1);
    step(17);
    check("chg_hold", 32'(dut.disp_bcd), 32'h000500);
    step(1);
    check("chg_second", 32'(dut.disp_bcd), 32'h000777);

    // Leading zeros for 42
    value = 17'd42;
    wait_idle("lz_idle");
`ifdef LEADING_ZERO_BLANK_EN
    see_digit(5, 7'h7F, "lz_d5");
    see_digit(3, 7'h7F, "lz_d3");
    see_digit(2, 7'h7F, "lz_d2");
`else
    see_digit(5, S0, "lz_d5");
    see_digit(3, S0, "lz_d3");
    see_digit(2, S0, "lz_d2");
`endif
    see_digit(1, S4, "lz_d1");
    see_digit(0, S2, "lz_d0");

    // Reset mid-conversion
    value = 17'd9999;
    step(9);
    check("mid_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_an", 32'(an), 32'h3F);
    check("async_seg", 32'(seg), 32'h7F);
    check("async_busy", 32'(busy), 0);
    check("async_bcd", 32'(dut.disp_bcd), 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("re_busy", 32'(busy), 1);
    check("re_seg0", 32'(seg), 32'(S0));
    step(17);
    check("re_busy17", 32'(busy), 1);
    step(1);
    check("re_idle", 32'(busy), 0);
    check("re_bcd", 32'(dut.disp_bcd), 32'h009999);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/duty_value_display.md
Name: duty_value_display

Overview:
- Downstream consumer of the duty-cycle measurement: takes the 17-bit `value` word and shows it in decimal on a 6-digit multiplexed common-anode seven-segment display.
- A sequential double-dabble converter turns binary into BCD only when the input changes.
- A refresh scanner then time-multiplexes the six BCD digits onto shared segment lines.

Parameters:
- DATA_W, 17: width of the binary input; max 131071, fits in 6 BCD digits.
- DIGITS, 6: number of display digits and anode lines.
- REFRESH_CNT_W, 16: width of the refresh prescaler; each digit is held for 2^REFRESH_CNT_W clk cycles.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- value  input  DATA_W  binary measurement; sampled every cycle, need not be stable between updates.
- an  output  DIGITS  anode enables, active-low, one-hot-low while scanning.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low; seg[0]=a.
- dp  output  1  decimal point, active-low, constant 1 (off).
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset is asynchronous and active-low. All state clears:
  - an=all 1s, seg=7'h7F, dp=1, busy=0.
  - disp_bcd=0, src_q=0, digit_idx=0, prescaler=0, FSM=IDLE.
- Conversion FSM (IDLE, CONV, DONE):
  - IDLE, when value != src_q at edge N: capture value into shift_q and cap_q; clear bcd_q (24 bits); bit_cnt=0; go to CONV. Otherwise stay in IDLE.
  - CONV, edges N+1..N+17: each cycle, add 3 to every BCD nibble >=5, then shift {bcd_q,shift_q} left by 1. bit_cnt increments. After the DATA_W-th shift, go to DONE.
  - DONE, edge N+18: disp_bcd<=bcd_q, src_q<=cap_q, go to IDLE. The new digits are visible from edge N+18.
  - busy=1 in CONV and DONE, registered with the state.
- value changes during CONV/DONE are ignored. On return to IDLE the compare against src_q starts a fresh conversion, so the last-applied value is always displayed eventually.
- Equal value never triggers a conversion. Post-reset, value=0 therefore causes no conversion and the display shows 0.
- Scanner:
  - The prescaler free-runs and wraps at 2^REFRESH_CNT_W-1. On the wrap edge, digit_idx increments modulo DIGITS (5 -> 0).
  - Registered outputs, one cycle after digit_idx/disp_bcd:
    - an = ~(1<<digit_idx).
    - seg = decode of nibble disp_bcd[4*digit_idx+:4].
  - The first cycle after reset release yields an=6'b111110 and seg of digit 0.
  - digit_idx 0 = least significant digit.
- Segment decode (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibbles 10-15 decode to 1111111 (blank); unreachable in normal operation.
- Reset mid-conversion: the FSM aborts, disp_bcd clears, and the display shows 0 (or is blanked per the Optional Feature).

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: any digit above digit 0 whose own nibble and all more-significant nibbles are zero outputs seg=7'h7F. Its anode still scans. Digit 0 always shows, so value 0 displays a single "0".
- Undefined: all six digits are always decoded, with leading zeros shown (e.g. 000042).

Decomposition:
- Shared package holds:
  - DATA_W and DIGITS defaults.
  - BCD nibble typedef (4-bit).
  - The 16-entry seven-segment pattern constant table.
  - FSM state enum {IDLE, CONV, DONE}.
- One natural sub-module: bin2bcd_seq, the IDLE/CONV/DONE double-dabble with value in and bcd/busy out.
- The scanner and decoder stay in the top block.

Test Plan:
- Reset: assert rst_n=0 mid-run -> an=6'h3F, seg=7'h7F, busy=0 immediately (asynchronous). Release with value=0 -> no busy pulse, digit 0 shows 7'b1000000.
- Conversion latency: value 0 -> 12345 at edge N -> busy high N..N+17, disp_bcd=24'h012345 at edge N+18, digit 2 decodes to 7'b0110000.
- Max value: value=131071 -> disp_bcd=24'h131071. Scanning with REFRESH_CNT_W=2 gives anodes 111110, 111101, …, 011111, then wraps to 111110 every 4 cycles.
- Change during conversion: 500 at edge N, 777 at edge N+5 -> first result 000500 at N+18, second conversion starts at N+19, 000777 shown at N+37.
- LEADING_ZERO_BLANK_EN defined, value=42 -> digits 5..2 seg=7'h7F, digit1=0011001, digit0=0100100. Undefined -> digits 5..2 show 1000000.
- Reset mid-CONV: rst_n low at edge N+8 -> FSM idle, disp_bcd=0. After release with value unchanged (nonzero), conversion restarts and completes 18 cycles later.
